seg7_scan_monitor: RTL and testbench

- Reverse path of the 7-segment digit decoder. Watches a multiplexed, active-low 7-segment display bus: digit enables plus shared segment lines.
- Recovers the 4-bit code that produced each digit's segment pattern, and flags patterns that are not in the code table.
- Sits beside the Timer display driver as a self-check and readback block. Drives board-level or bench checkers, and can feed loopback registers.

---
 rtl/seg7_scan_monitor_if.sv | 28 ++
 rtl/seg7_scan_monitor.sv | 130 +++++++++++++
 tb/tb_seg7_scan_monitor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_monitor_if.sv
// Display-bus bundle for the 7-segment scan monitor.
// Carries the observed digit enables / segment lines and the recovered codes,
// error flags and frame-complete pulse. The driver side uses master, the monitor uses slave.
interface seg7_scan_monitor_if #(
    parameter int N_DIG = 4
);
    logic [N_DIG-1:0]   i_an;   // digit enables, active-low
    logic [6:0]         i_seg;  // segments, active-low, bit0 = a .. bit6 = g
    logic [4*N_DIG-1:0] o_dat;  // recovered codes, digit i at [4i+3:4i]
    logic [N_DIG-1:0]   o_err;  // last capture for digit i was not a table pattern
    logic               o_vld;  // one-cycle frame-complete pulse

    modport master (
        output i_an,
        output i_seg,
        input  o_dat,
        input  o_err,
        input  o_vld
    );

    modport slave (
        input  i_an,
        input  i_seg,
        output o_dat,
        output o_err,
        output o_vld
    );
endinterface

// File: rtl/seg7_scan_monitor.sv
// Recovers 4-bit codes from a multiplexed active-low 7-segment bus and flags unknown patterns.
// Latency: capture lands STABLE+1 edges after the first edge that samples a constant input.
// Backpressure: none; passive observer, outputs are registered and never stall the bus.
//
// Ports: i_clk, i_rst (synchronous, active-high); bus.i_an / bus.i_seg observed,
//        bus.o_dat / bus.o_err / bus.o_vld produced.
module seg7_scan_monitor #(
    parameter int N_DIG  = 4,
    parameter int STABLE = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seg7_scan_monitor_if.slave    bus
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE);
    localparam logic [3:0] RUN_CAP = 4'(STABLE - 1);

    // Synchroniser stages and the previous synchronised sample.
    logic [N_DIG-1:0]   s1_an,  s2_an,  p2_an;
    logic [6:0]         s1_seg, s2_seg, p2_seg;

    logic [3:0]         run;
    logic [N_DIG-1:0]   seen;
    logic [4*N_DIG-1:0] dat_q;
    logic [N_DIG-1:0]   err_q;
    logic               vld_q;

    logic               sample_ok;
    logic               same;
    logic               capture;
    logic [4:0]         dec;
    logic [N_DIG-1:0]   seen_upd;
    logic               frame_done;

    // Returns {hit, code}; hit is 0 for patterns outside the table.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0011000: r = {1'b1, 4'h9};
            7'b1111111: r = {1'b1, 4'hA};  // blank digit
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        // Exactly one enable low means a digit is being driven; anything else is idle.
        sample_ok = $onehot(~s2_an);
        same      = (s2_an == p2_an) && (s2_seg == p2_seg);
        // Fires only on the STABLE-1 -> STABLE step, so a long window captures once.
        capture   = sample_ok && same && (run == RUN_CAP);
        dec       = decode(s2_seg);
        seen_upd  = seen;
        for (int i = 0; i < N_DIG; i++) begin
            if (!s2_an[i]) begin
                seen_upd[i] = 1'b1;
            end
        end
        frame_done = capture && (&seen_upd);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_an  <= '1;
            s1_seg <= '1;
            s2_an  <= '1;
            s2_seg <= '1;
            p2_an  <= '1;
            p2_seg <= '1;
            run    <= '0;
            seen   <= '0;
            dat_q  <= '0;
            err_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            s1_an  <= bus.i_an;
            s1_seg <= bus.i_seg;
            s2_an  <= s1_an;
            s2_seg <= s1_seg;
            p2_an  <= s2_an;
            p2_seg <= s2_seg;

            if (!sample_ok) begin
                run <= '0;
            end else if (same) begin
                if (run != RUN_MAX) begin
                    run <= run + 4'd1;
                end
            end else begin
                run <= 4'd1;
            end

            vld_q <= frame_done;

            if (capture) begin
                for (int i = 0; i < N_DIG; i++) begin
                    if (!s2_an[i]) begin
                        // A miss keeps the last good code and only raises the flag.
                        if (dec[4]) begin
                            dat_q[4*i +: 4] <= dec[3:0];
                        end
                        err_q[i] <= ~dec[4];
                    end
                end
                seen <= frame_done ? '0 : seen_upd;
            end
        end
    end

    assign bus.o_dat = dat_q;
    assign bus.o_err = err_q;
    assign bus.o_vld = vld_q;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
module tb_seg7_scan_monitor;
    localparam int N  = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_monitor_if #(.N_DIG(N)) bus ();

    seg7_scan_monitor #(.N_DIG(N), .STABLE(ST)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int               cyc;
        logic [4*N-1:0]   dat;
        logic [N-1:0]     err;
        logic             vld;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Code table: index = code, entry = active-low pattern g..a.
    logic [6:0] patt [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b1111111, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state: what the display has been showing, at sample level.
    int           m_code [N];
    logic [N-1:0] m_err;
    logic [N-1:0] m_seen;
    int           streak;
    bit           m_pv;
    logic [N-1:0] m_pan;
    logic [6:0]   m_pseg;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // c is the clock edge that samples (an, seg). A window of ST identical valid
    // samples is captured; the DUT's two sync stages push the result to edge c+2.
    task automatic model(input int c, input logic [N-1:0] an, input logic [6:0] seg, input bit r);
        exp_t e;
        int   d;
        int   code;
        bit   valid;
        if (r) begin
            for (int i = 0; i < N; i++) m_code[i] = 0;
            m_err  = '0;
            m_seen = '0;
            streak = 0;
            m_pv   = 0;
            e.cyc = c; e.dat = '0; e.err = '0; e.vld = 1'b0;
            q.push_back(e);
            return;
        end
        valid = ($countones(~an) == 1);
        if (valid && m_pv && an == m_pan && seg == m_pseg) streak++;
        else streak = valid ? 1 : 0;
        m_pv = valid; m_pan = an; m_pseg = seg;
        if (streak == ST) begin
            d = 0;
            for (int i = 0; i < N; i++) if (an[i] == 1'b0) d = i;
            code = -1;
            for (int k = 0; k < 16; k++) if (patt[k] == seg) code = k;
            if (code >= 0) begin
                m_code[d] = code;
                m_err[d]  = 1'b0;
            end else begin
                m_err[d]  = 1'b1;
            end
            m_seen[d] = 1'b1;
            e.vld = (m_seen == {N{1'b1}});
            if (e.vld) m_seen = '0;
            e.cyc = c + 2;
            for (int i = 0; i < N; i++) e.dat[4*i +: 4] = 4'(m_code[i]);
            e.err = m_err;
            q.push_back(e);
        end
    endtask

    task automatic step(input logic [N-1:0] an, input logic [6:0] seg, input bit r);
        @(negedge clk);
        bus.i_an  = an;
        bus.i_seg = seg;
        rst       = r;
        model(cyc + 1, an, seg, r);
    endtask

    task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(an, seg, 1'b0);
    endtask

    task automatic idle(input int n);
        hold({N{1'b1}}, 7'h7F, n);
    endtask

    task automatic do_reset();
        idle(3);
        step({N{1'b1}}, 7'h7F, 1'b1);
        idle(2);
    endtask

    function automatic logic [N-1:0] dig(input int d);
        logic [N-1:0] a;
        a = {N{1'b1}};
        a[d] = 1'b0;
        return a;
    endfunction

    // Monitor: expected events are keyed by cycle; between events outputs must hold.
    logic [4*N-1:0] exp_dat;
    logic [N-1:0]   exp_err;
    bit             armed = 0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check("dat", 32'(bus.o_dat), 32'(e.dat));
            check("err", 32'(bus.o_err), 32'(e.err));
            check("vld", 32'(bus.o_vld), 32'(e.vld));
            exp_dat = e.dat;
            exp_err = e.err;
            armed   = 1;
        end else if (armed) begin
            check("hold", {bus.o_vld, 11'd0, bus.o_err, bus.o_dat},
                          {1'b0, 11'd0, exp_err, exp_dat});
        end
    end

    initial begin
        rst       = 1'b1;
        bus.i_an  = {N{1'b1}};
        bus.i_seg = 7'h7F;
        step({N{1'b1}}, 7'h7F, 1'b1);
        idle(3);

        // Single digit held long: one capture, no frame pulse.
        hold(dig(0), patt[0], 10);
        idle(4);

        // Full scan 1,2,3,4: frame pulse with digit 3.
        for (int d = 0; d < N; d++) hold(dig(d), patt[d + 1], 8);
        idle(4);

        // Glitch: two cycles is too short, three is enough.
        hold(dig(1), patt[2], 2);
        idle(4);
        hold(dig(1), patt[2], 3);
        idle(4);

        // Unknown pattern then a valid E on digit 2.
        hold(dig(2), 7'b0101010, 6);
        idle(3);
        hold(dig(2), patt[14], 5);
        idle(3);

        // Two enables low is idle; moving to a single enable starts a fresh window.
        hold(4'b1100, patt[5], 10);
        hold(4'b1101, patt[5], 5);
        idle(3);

        // Blank digit 3.
        hold(dig(3), 7'b1111111, 5);
        idle(3);

        // Partial frame then reset: needs a full rescan before the next pulse.
        for (int d = 0; d < 3; d++) hold(dig(d), patt[d + 6], 5);
        do_reset();
        hold(dig(3), patt[9], 5);
        for (int d = 0; d < N; d++) hold(dig(d), patt[d + 11], 4);
        idle(3);

        // Randomised scanning.
        for (int it = 0; it < 400; it++) begin
            logic [N-1:0] an;
            logic [6:0]   sg;
            int           n;
            if ($urandom_range(0, 9) < 8) an = dig($urandom_range(0, N - 1));
            else an = N'($urandom);
            if ($urandom_range(0, 9) < 8) sg = patt[$urandom_range(0, 15)];
            else sg = 7'($urandom);
            n = $urandom_range(1, 6);
            hold(an, sg, n);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        idle(8);
        check("drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
